// File: rtl/game_clock_pkg.sv
// game_clock_pkg: shared FSM state and time-control mode types for game_clock
package common_enums;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } clock_state_t;
    typedef enum logic [1:0] {
        MODE_SUDDEN = 2'd0,
        MODE_INC    = 2'd1,
        MODE_DELAY  = 2'd2,
        MODE_RSVD   = 2'd3
    } clock_mode_t;
endpackage

// File: rtl/game_clock_tick_gen.sv
// tick_gen: 1 s prescaler counting 0..CLK_FREQ_HZ-1 while enabled; tick flags the wrap cycle
module tick_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_FREQ_HZ - 1);
    logic [PW-1:0] cnt_q, cnt_d;
    assign tick = enable && (cnt_q == LAST);
    // clear wins; otherwise hold when disabled, wrap on the last count
    always_comb cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + PW'(1);
    // prescaler count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/game_clock.sv
// game_clock: multi-player game clock (sudden death / increment / delay); delay mode is built only when GAME_CLOCK_DELAY_EN is defined
module game_clock import common_enums::*; #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int NUM_PLAYERS = 2,
    parameter int SEC_W       = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           move_done,
    input  logic [1:0]                     mode,
    input  logic [SEC_W-1:0]               base_sec,
    input  logic [7:0]                     inc_sec,
    output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
    output logic [NUM_PLAYERS*SEC_W-1:0]   time_left,
    output clock_state_t                   state,
    output logic                           time_up,
    output logic [$clog2(NUM_PLAYERS)-1:0] loser,
    output logic                           tick
);
    localparam int AW = $clog2(NUM_PLAYERS);
    localparam int SW = ((SEC_W > 8) ? SEC_W : 8) + 1;
    localparam logic [SW-1:0] MAXV = (SW'(1) << SEC_W) - SW'(1);
    clock_state_t state_q, state_d;
    clock_mode_t mode_q, mode_d;
    logic [7:0] inc_q, inc_d;
    logic [AW-1:0] ap_q, ap_d, loser_q, loser_d;
    logic [SEC_W-1:0] tl_q [NUM_PLAYERS];
    logic [SEC_W-1:0] tl_d [NUM_PLAYERS];
    logic [SEC_W-1:0] cur;
    logic [SW-1:0] sum;
    logic tick_q, tick_d, time_up_q, wrap, clr, hold, run;
`ifdef GAME_CLOCK_DELAY_EN
    logic [7:0] dly_q, dly_d;
`endif
    assign run = (state_q == RUN);
    tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk(clk),
        .reset(reset),
        .enable(run),
        .clear(clr),
        .tick(wrap)
    );
    // next-state: start reloads from anywhere; in RUN the tick is applied before move_done
    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        inc_d = inc_q;
        ap_d = ap_q;
        loser_d = loser_q;
        tl_d = tl_q;
        tick_d = 1'b0;
        clr = 1'b0;
        cur = tl_q[ap_q];
        sum = '0;
`ifdef GAME_CLOCK_DELAY_EN
        dly_d = dly_q;
        hold = (mode_q == MODE_DELAY) && (dly_q != '0);
`else
        hold = 1'b0;
`endif
        if (start) begin
            state_d = RUN;
            mode_d = clock_mode_t'(mode);
            inc_d = inc_sec;
            ap_d = '0;
            loser_d = '0;
            clr = 1'b1;
            for (int i = 0; i < NUM_PLAYERS; i++) tl_d[i] = base_sec;
`ifdef GAME_CLOCK_DELAY_EN
            dly_d = inc_sec;
`endif
        end else if (run) begin
            if (wrap && cur != '0) begin
                tick_d = 1'b1;
                if (!hold) cur = cur - SEC_W'(1);
`ifdef GAME_CLOCK_DELAY_EN
                if (hold) dly_d = dly_q - 8'd1;
`endif
            end
            if (cur == '0) begin
                state_d = EXPIRED;
                loser_d = ap_q;
            end else begin
                if (move_done) begin
                    sum = SW'(cur) + SW'(inc_q);
                    if (mode_q == MODE_INC) cur = (sum > MAXV) ? '1 : SEC_W'(sum);
                    ap_d = (ap_q == AW'(NUM_PLAYERS - 1)) ? '0 : ap_q + AW'(1);
                    clr = 1'b1;
`ifdef GAME_CLOCK_DELAY_EN
                    dly_d = inc_q;
`endif
                end
                if (pause) state_d = PAUSED;
            end
            tl_d[ap_q] = cur;
        end else if (state_q == PAUSED && pause) begin
            state_d = RUN;
        end
    end
    // game state, player clocks and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q <= MODE_SUDDEN;
            inc_q <= '0;
            ap_q <= '0;
            loser_q <= '0;
            tl_q <= '{default: '0};
            tick_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            inc_q <= inc_d;
            ap_q <= ap_d;
            loser_q <= loser_d;
            tl_q <= tl_d;
            tick_q <= tick_d;
            time_up_q <= (state_d == EXPIRED);
        end
    end
`ifdef GAME_CLOCK_DELAY_EN
    // per-turn delay allowance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dly_q <= '0;
        else dly_q <= dly_d;
    end
`endif
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_tl
        assign time_left[g*SEC_W +: SEC_W] = tl_q[g];
    end
    assign active_player = ap_q;
    assign state = state_q;
    assign time_up = time_up_q;
    assign loser = loser_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_game_clock.sv
// tb_game_clock: randomized + directed scoreboard bench for game_clock (CLK_FREQ_HZ=10, 3 players, 8-bit seconds)
module tb_game_clock;
    localparam int CLK = 10;
    localparam int NP = 3;
    localparam int W = 8;
    localparam int TMAX = (1 << W) - 1;
`ifdef GAME_CLOCK_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pause = 1'b0, move_done = 1'b0;
    logic [1:0] mode = '0;
    logic [W-1:0] base_sec = '0;
    logic [7:0] inc_sec = '0;
    logic [1:0] active_player, loser, state_o;
    logic [NP*W-1:0] time_left;
    logic time_up, tick;

    game_clock #(.CLK_FREQ_HZ(CLK), .NUM_PLAYERS(NP), .SEC_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pause(pause),
        .move_done(move_done),
        .mode(mode),
        .base_sec(base_sec),
        .inc_sec(inc_sec),
        .active_player(active_player),
        .time_left(time_left),
        .state(state_o),
        .time_up(time_up),
        .loser(loser),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] ap;
        logic [1:0] lo;
        logic tu;
        logic tk;
        logic [NP*W-1:0] tl;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_err = 0;

    // reference model: game-level quantities (states 0 idle, 1 run, 2 paused, 3 expired)
    int m_st, m_ap, m_lo, m_tk, m_pre, m_dly, m_mode, m_inc;
    int m_tl[NP];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int tlv(int i);
        return int'(time_left[i*W +: W]);
    endfunction

    function automatic void model_reset();
        m_st = 0; m_ap = 0; m_lo = 0; m_tk = 0; m_pre = 0; m_dly = 0; m_mode = 0; m_inc = 0;
        for (int i = 0; i < NP; i++) m_tl[i] = 0;
    endfunction

    function automatic void step();
        m_tk = 0;
        if (start) begin
            for (int i = 0; i < NP; i++) m_tl[i] = int'(base_sec);
            m_ap = 0; m_pre = 0; m_mode = int'(mode); m_inc = int'(inc_sec);
            m_dly = m_inc; m_st = 1; m_lo = 0;
        end else if (m_st == 1) begin
            bit wr;
            wr = (m_pre == CLK - 1);
            m_pre = wr ? 0 : m_pre + 1;
            if (m_tl[m_ap] == 0) begin
                m_st = 3; m_lo = m_ap;
            end else begin
                if (wr) begin
                    m_tk = 1;
                    if (DLY && m_mode == 2 && m_dly > 0) m_dly--;
                    else m_tl[m_ap]--;
                end
                if (m_tl[m_ap] == 0) begin
                    m_st = 3; m_lo = m_ap;
                end else begin
                    if (move_done) begin
                        if (m_mode == 1) m_tl[m_ap] = (m_tl[m_ap] + m_inc > TMAX) ? TMAX : m_tl[m_ap] + m_inc;
                        m_ap = (m_ap + 1) % NP;
                        m_pre = 0;
                        m_dly = m_inc;
                    end
                    if (pause) m_st = 2;
                end
            end
        end else if (m_st == 2 && pause) begin
            m_st = 1;
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.st = 2'(m_st); e.ap = 2'(m_ap); e.lo = 2'(m_lo);
        e.tu = (m_st == 3); e.tk = m_tk[0];
        for (int i = 0; i < NP; i++) e.tl[i*W +: W] = W'(m_tl[i]);
        return e;
    endfunction

    // monitor: every cycle the DUT presents registered outputs; compare against queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_state", int'(state_o), int'(e.st));
                chk("sb_active", int'(active_player), int'(e.ap));
                chk("sb_loser", int'(loser), int'(e.lo));
                chk("sb_time_up", int'(time_up), int'(e.tu));
                chk("sb_tick", int'(tick), int'(e.tk));
                for (int i = 0; i < NP; i++) chk($sformatf("sb_time_left%0d", i), tlv(i), int'(e.tl[i*W +: W]));
            end
        end
    end

    task automatic rst_chk(string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_active"}, int'(active_player), 0);
        chk({tag, "_loser"}, int'(loser), 0);
        chk({tag, "_time_up"}, int'(time_up), 0);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_time_left"}, int'(time_left), 0);
    endtask

    // called at a negedge: async reset must clear outputs before the next clock edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        rst_chk("midreset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cyc(input bit s, input bit p, input bit m);
        start = s; pause = p; move_done = m;
        @(posedge clk);
        step();
        q.push_back(snap());
        @(negedge clk);
        start = 1'b0; pause = 1'b0; move_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input int md, input int b, input int inc);
        mode = 2'(md); base_sec = W'(b); inc_sec = 8'(inc);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    localparam int D_T0 = DLY ? 3 : 1;
    localparam int D_T1 = DLY ? 5 : 3;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_chk("por");
        reset = 1'b0;
        // sudden death runs out after 3 s
        go(0, 3, 0);
        idle(30);
        chk("sd_tl0", tlv(0), 0);
        chk("sd_tl1", tlv(1), 3);
        chk("sd_tl2", tlv(2), 3);
        chk("sd_time_up", int'(time_up), 1);
        chk("sd_loser", int'(loser), 0);
        // increment mode and player rotation
        go(1, 5, 2);
        idle(10);
        chk("inc_tl0_tick", tlv(0), 4);
        cyc(1'b0, 1'b0, 1'b1);
        chk("inc_tl0", tlv(0), 6);
        chk("inc_ap1", int'(active_player), 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("inc_wrap_ap", int'(active_player), 0);
        // delay mode (sudden death when delay support is not built)
        go(2, 5, 2);
        idle(40);
        chk("dly_tl0", tlv(0), D_T0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(20);
        chk("dly_tl1", tlv(1), D_T1);
        // coincident tick and move_done on the last second
        go(0, 1, 0);
        idle(9);
        cyc(1'b0, 1'b0, 1'b1);
        chk("coin_state", int'(state_o), 3);
        chk("coin_loser", int'(loser), 0);
        chk("coin_ap", int'(active_player), 0);
        // pause holds the prescaler at 4
        go(0, 9, 0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0);
        idle(50);
        chk("pause_state", int'(state_o), 2);
        chk("pause_tl0", tlv(0), 9);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("resume_no_tick", int'(tick), 0);
        end
        idle(1);
        chk("resume_tick", int'(tick), 1);
        chk("resume_tl0", tlv(0), 8);
        // zero base time expires one cycle after start
        go(0, 0, 0);
        chk("zero_run", int'(state_o), 1);
        idle(1);
        chk("zero_expired", int'(state_o), 3);
        chk("zero_loser", int'(loser), 0);
        // saturation, then reset mid-run
        go(1, 254, 5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("sat_tl0", tlv(0), 255);
        idle(3);
        do_reset();
        // randomized play
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            else if ($urandom_range(0, 149) == 0) go(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            else cyc($urandom_range(0, 999) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/game_clock.md
GAME_CLOCK -- requirements
Module: game_clock

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the clk frequency used to derive the 1 s tick.
REQ-002 SHALL have parameter NUM_PLAYERS, default 2, meaning the number of player clocks (legal range 2..8).
REQ-003 SHALL have parameter SEC_W, default 12, meaning the width in bits of each seconds counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse; loads the clocks and begins play.
REQ-008 pause  in  1  single-cycle pulse; toggles between RUN and PAUSED.
REQ-009 move_done  in  1  single-cycle pulse; the active player has completed a move.
REQ-010 mode  in  2  time-control mode: 0 = sudden death, 1 = increment, 2 = delay, 3 = reserved (treated as 0).
REQ-011 base_sec  in  SEC_W  starting time per player, sampled on start.
REQ-012 inc_sec  in  8  increment or delay value in seconds, sampled on start.
REQ-013 active_player  out  $clog2(NUM_PLAYERS)  index of the player whose clock is running.
REQ-014 time_left  out  NUM_PLAYERS x SEC_W  remaining seconds for each player.
REQ-015 state  out  2  current FSM state, encoded as clock_state_t.
REQ-016 time_up  out  1  high while in EXPIRED.
REQ-017 loser  out  $clog2(NUM_PLAYERS)  index of the player whose clock reached 0.
REQ-018 tick  out  1  single-cycle pulse on every 1 s prescaler wrap.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN, PAUSED and EXPIRED.
REQ-020 IDLE -> RUN on start: every time_left is loaded with base_sec, active_player is set to 0, the prescaler is cleared, and mode and inc_sec are latched.
REQ-021 start SHALL be accepted in any state and restarts the game (reload as in REQ-020).
REQ-022 RUN <-> PAUSED on pause; while PAUSED the prescaler SHALL hold its value and move_done SHALL be ignored.
REQ-023 The prescaler SHALL count 0..CLK_FREQ_HZ-1 only while in RUN; tick is asserted on the cycle the count wraps.
REQ-024 On tick in RUN, time_left[active_player] SHALL decrement by 1, except as defined in REQ-029.
REQ-025 When a decrement makes the value 0, the next state SHALL be EXPIRED, with loser = active_player and time_up = 1.
REQ-026 On move_done in RUN, mode 1 SHALL add inc_sec to time_left[active_player], saturating at 2^SEC_W-1.
REQ-027 On move_done in RUN, active_player SHALL advance, wrapping NUM_PLAYERS-1 -> 0, and the prescaler SHALL clear.
REQ-028 If tick and move_done occur in the same cycle, the tick is applied first; if the flag falls, move_done is discarded, otherwise decrement, then increment, then advance.
REQ-029 In mode 2, the first inc_sec ticks of each turn SHALL NOT decrement the clock; the delay counter reloads on every move_done and on start.
REQ-030 EXPIRED SHALL be left only by start or reset; tick is not generated in EXPIRED.
REQ-031 A base_sec of 0 on start SHALL enter EXPIRED on the next cycle with loser = 0.
REQ-032 All outputs SHALL be registered; the latency from move_done to the updated active_player is 1 cycle.

Reset
REQ-033 On reset SHALL force: state = IDLE, all time_left = 0, active_player = 0, loser = 0, time_up = 0, tick = 0, prescaler = 0, delay counter = 0.
REQ-034 Reset asserted mid-game SHALL abort immediately; no tick or move_done is applied in that cycle.

Configuration
REQ-035 The macro GAME_CLOCK_DELAY_EN SHALL control delay mode: when defined, mode 2 behaves per REQ-029; when undefined, the delay counter is not built and mode 2 behaves as mode 0.

Structure
REQ-036 The types clock_state_t (IDLE, RUN, PAUSED, EXPIRED) and clock_mode_t SHALL be declared in the common_enums package.
REQ-037 The prescaler SHALL be a sub-module named tick_gen with parameter CLK_FREQ_HZ and enable, clear and tick ports.

Verification (CLK_FREQ_HZ = 10, NUM_PLAYERS = 3, SEC_W = 8)
REQ-038 start with base_sec = 3, mode 0 -> after 30 cycles time_left[0] = 0, time_up = 1, loser = 0, players 1 and 2 still at 3.
REQ-039 mode 1, inc_sec = 2, base_sec = 5; move_done after 1 tick -> time_left[0] = 6, active_player = 1; three move_done pulses wrap active_player back to 0.
REQ-040 mode 2, inc_sec = 2, base_sec = 5; wait 4 ticks -> time_left[0] = 3; move_done, then 2 ticks -> time_left[1] = 5.
REQ-041 time_left[0] = 1 with tick and move_done coincident -> EXPIRED, loser = 0, active_player unchanged.
REQ-042 pause at prescaler count 4, hold 50 cycles, pause again -> the next tick comes 6 cycles later and time_left is unchanged during the pause.
REQ-043 base_sec = 254, mode 1, inc_sec = 5, move_done -> time_left[0] saturates at 255; reset asserted mid-RUN -> all outputs at their reset values on the same edge.
